// File: rtl/bus_bridge_req_serializer.sv
// Request-side serializer of the bus bridge.
// Takes one captured bus-A transaction and sends it on an 8N1 UART line as a
// frame of header, addr_hi, addr_lo and, for writes only, data.
// Only one transaction is in flight at a time. The front end is held off
// through req_ready while a frame is being sent.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | line high, req_ready high, waiting for a request
// START | driving the start bit (0) of the current byte
// DATA  | driving data bit bit_idx_q of the current byte, LSB first
// STOP  | driving the stop bit (1); then the next byte or IDLE
module bus_bridge_req_serializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [6:0]  HDR_MAGIC    = 7'h50
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_data,
  input  logic        req_rw,
  output logic        uart_tx,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [2:0]    byte_cnt_q;
  logic [31:0]   frame_q;
  logic          frame_done_q;

  logic          accept;
  logic          bit_end;
  logic          last_byte;

  assign accept    = (state_q == IDLE) && req_valid;
  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_byte = (byte_cnt_q == 3'd1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode. Every bit, including the start and stop bits, lasts one baud period.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (req_valid) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
      STOP:  if (bit_end) state_d = last_byte ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // Frame capture, baud counter, bit index and byte counter.
  // The current byte always sits in frame_q[31:24].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
      frame_q    <= '0;
    end else if (state_q == IDLE) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      if (accept) begin
        frame_q    <= {HDR_MAGIC, req_rw, req_addr, req_data};
        byte_cnt_q <= req_rw ? 3'd4 : 3'd3;
      end
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      if (bit_end && (state_q == DATA)) bit_idx_q <= bit_idx_q + 3'd1;
      if (bit_end && (state_q == STOP)) begin
        byte_cnt_q <= byte_cnt_q - 3'd1;
        frame_q    <= {frame_q[23:0], 8'h00};
      end
    end
  end

  // Completion pulse. It is high for the first IDLE cycle after the last stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done_q <= 1'b0;
    else        frame_done_q <= (state_q == STOP) && bit_end && last_byte;
  end

  // Line driver. The line is decoded from registered state only, so an async reset returns it high at once.
  always_comb begin
    uart_tx = 1'b1;
    unique case (state_q)
      START:   uart_tx = 1'b0;
      DATA:    uart_tx = frame_q[{2'b11, bit_idx_q}];
      default: uart_tx = 1'b1;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bus_bridge_req_serializer.sv
// Scoreboard bench for bus_bridge_req_serializer with CLKS_PER_BIT=4.
// The stimulus pushes the expected frame bytes into a queue. A UART monitor
// decodes the line and pops the queue for each byte.
module tb_bus_bridge_req_serializer;

  localparam int CPB = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic [7:0]  req_data;
  logic        req_rw;
  logic        uart_tx;
  logic        busy;
  logic        frame_done;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  bus_bridge_req_serializer #(.CLKS_PER_BIT(CPB), .HDR_MAGIC(7'h50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_rw     (req_rw),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required run to finish");
    n_err++;
    $fatal(1, "watchdog");
  end

  // Monitor: each byte must be 10 bits of exactly CPB cycles each, with start 0 and stop 1.
  initial begin
    logic [10*CPB-1:0] s;
    bit aborted;
    bit frm_ok;
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx == 1'b0) begin
        s = '0;
        s[0] = uart_tx;
        aborted = 1'b0;
        for (int i = 1; i < 10*CPB; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          s[i] = uart_tx;
        end
        if (!aborted) begin
          frm_ok = 1'b1;
          for (int bi = 0; bi < 10; bi++)
            for (int c = 1; c < CPB; c++)
              if (s[bi*CPB+c] != s[bi*CPB]) frm_ok = 1'b0;
          if (s[0] != 1'b0 || s[9*CPB] != 1'b1) frm_ok = 1'b0;
          for (int bi = 0; bi < 8; bi++) b[bi] = s[(bi+1)*CPB];
          n_vec++;
          if (exp_q.size() == 0) begin
            $display("FAIL rx_byte: got unexpected byte %02h, required no byte", b);
            n_err++;
          end else begin
            e = exp_q.pop_front();
            if (!frm_ok || b != e) begin
              $display("FAIL rx_byte: got %02h framing_ok=%0d, required %02h framing_ok=1", b, frm_ok, e);
              n_err++;
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input bit ok, input string detail);
    n_vec++;
    if (!ok) begin
      $display("FAIL %s: %s", name, detail);
      n_err++;
    end
  endtask

  // Called just after a negedge. It returns just after the negedge of the frame_done cycle.
  task automatic send(input logic [15:0] a, input logic [7:0] d, input logic rw,
                      input bit keep, input bit noise);
    int k;
    int lim;
    int exp_cyc;
    bit ready_err;
    lim = 0;
    while (!req_ready && lim < 1000) begin
      @(negedge clk);
      lim++;
    end
    if (!req_ready) begin
      check("ready_wait", 1'b0, "req_ready never rose, required 1");
      return;
    end
    req_addr = a;
    req_data = d;
    req_rw = rw;
    req_valid = 1'b1;
    exp_q.push_back({7'h50, rw});
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    if (rw) exp_q.push_back(d);
    exp_cyc = (rw ? 40 : 30) * CPB;
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    check("accept", uart_tx == 1'b0 && req_ready == 1'b0 && busy == 1'b1,
          $sformatf("tx=%0b ready=%0b busy=%0b, required tx=0 ready=0 busy=1", uart_tx, req_ready, busy));
    ready_err = 1'b0;
    k = 0;
    while (k < 1000) begin
      @(negedge clk);
      k++;
      if (noise) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr = 16'($urandom);
        req_data = 8'($urandom);
        req_rw = 1'($urandom_range(0, 1));
      end
      if (frame_done) break;
      if (req_ready) ready_err = 1'b1;
    end
    if (noise || !keep) req_valid = 1'b0;
    check("frame_len", k == exp_cyc && !ready_err && uart_tx == 1'b1 && req_ready == 1'b1,
          $sformatf("done_at=%0d ready_glitch=%0b tx=%0b ready=%0b, required done_at=%0d ready_glitch=0 tx=1 ready=1",
                    k, ready_err, uart_tx, req_ready, exp_cyc));
  endtask

  initial begin
    bit quiet;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    req_rw = 1'b0;
    #12;
    check("reset", uart_tx == 1'b1 && req_ready == 1'b1 && busy == 1'b0 && frame_done == 1'b0,
          $sformatf("tx=%0b ready=%0b busy=%0b done=%0b, required 1 1 0 0", uart_tx, req_ready, busy, frame_done));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write: A1 12 34 5A, 160 cycles.
    send(16'h1234, 8'h5A, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Read: A0 80 01, data byte never sent.
    send(16'h8001, 8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Noise on the request inputs while busy.
    send(16'hBEEF, 8'h77, 1'b1, 1'b0, 1'b1);
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (!(req_ready && uart_tx && !frame_done)) quiet = 1'b0;
    end
    check("no_second_accept", quiet, $sformatf("quiet=%0b, required 1", quiet));

    // Back-to-back writes with valid held high.
    send(16'h0000, 8'h11, 1'b1, 1'b1, 1'b0);
    send(16'h4FFF, 8'h22, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset during the addr_hi byte of a write. Only the header completes.
    req_addr = 16'hABCD;
    req_data = 8'h33;
    req_rw = 1'b1;
    req_valid = 1'b1;
    exp_q.push_back(8'hA1);
    @(negedge clk);
    req_valid = 1'b0;
    quiet = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (frame_done) quiet = 1'b0;
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", uart_tx == 1'b1 && req_ready == 1'b1 && busy == 1'b0 && frame_done == 1'b0 && quiet,
          $sformatf("tx=%0b ready=%0b busy=%0b done=%0b no_early_done=%0b, required 1 1 0 0 1",
                    uart_tx, req_ready, busy, frame_done, quiet));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("header_before_reset", exp_q.size() == 0,
          $sformatf("pending=%0d, required 0", exp_q.size()));
    exp_q.delete();
    repeat (2) @(negedge clk);

    send(16'h0010, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size() == 0, $sformatf("pending=%0d, required 0", exp_q.size()));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
